// File: rtl/cim_mem_arbiter_pkg.sv
// Shared CIM definitions: requester indices, arbiter states and storage sizing.
// Imported by the memory arbiter and the other CIM schedulers.
package cim_mem_arbiter_pkg;

    // Requester positions in every per-engine request vector
    typedef enum logic [2:0] {
        BUS_FSM                  = 3'd0,
        LOGIC_FSM                = 3'd1,
        MAC                      = 3'd2,
        LAYERNORM                = 3'd3,
        DATA_FILL_FSM            = 3'd4,
        DENSE_BROADCAST_SAVE_FSM = 3'd5
    } cim_req_e;

    localparam int CIM_N_REQ = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int N_STORAGE     = 16;
    localparam int INT_RES_DEPTH = 2048;
    localparam int PARAMS_DEPTH  = 2048;
    localparam int CIM_ADDR_W    = 11;

endpackage

// File: rtl/cim_mem_arbiter_if.sv
// Requester and memory-side bus of one CIM memory bank arbiter.
// slave = the arbiter, master = the engines plus the memory macro.
interface cim_mem_arbiter_if
    import cim_mem_arbiter_pkg::*;
#(
    parameter int N_REQ  = CIM_N_REQ,
    parameter int ADDR_W = CIM_ADDR_W,
    parameter int DATA_W = N_STORAGE
);
    // Handshake: a requester holds req/req_we/req_lock/addr/wdata until it sees
    // gnt in the same cycle; the access takes effect at the next clk edge, and a
    // granted read returns one cycle later as rvalid (one-hot) with rdata.
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             req_we;
    logic [N_REQ-1:0]             req_lock;
    logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]            rdata;

    logic                         mem_en;
    logic                         mem_wen;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_wdata;
    logic [DATA_W-1:0]            mem_rdata;

    modport master (
        output req, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  req, req_we, req_lock, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_en, mem_wen, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cim_mem_arbiter_rr_picker.sv
// Combinational round-robin select: first set mask bit at or after rr_ptr,
// wrapping; one-hot result. Rotate, isolate lowest bit, rotate back.
module rr_picker #(
    parameter int N     = 6,
    parameter int PTR_W = 3
) (
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     sel
);
    logic [N-1:0] rot;
    logic [N-1:0] first;

    assign rot   = N'({mask, mask} >> rr_ptr);
    assign first = rot & (~rot + N'(1));
    assign sel   = N'({first, first} >> (N - int'(rr_ptr)));

endmodule

// File: rtl/cim_mem_arbiter.sv
// Single-port CIM bank arbiter: BUS_FSM fixed priority, round-robin for the
// other engines, optional multi-cycle lock with timeout, tagged read return.
module cim_mem_arbiter
    import cim_mem_arbiter_pkg::*;
#(
    parameter int N_REQ        = CIM_N_REQ,
    parameter int ADDR_W       = CIM_ADDR_W,
    parameter int DATA_W       = N_STORAGE,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    cim_mem_arbiter_if.slave bus,
    output logic             busy,
    output logic             err_mac_write,
    output logic             err_lock_timeout,
    output arb_state_e       dbg_state
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] k);
        if (k >= PTR_W'(N_REQ - 1)) begin
            return PTR_W'(1);
        end
        return k + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) idx = PTR_W'(i);
        end
        return idx;
    endfunction

    arb_state_e        state, state_nxt;
    logic [PTR_W-1:0]  owner, owner_nxt;
    logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
    logic [PTR_W-1:0]  win_idx, gnt_idx;
    logic [N_REQ-1:0]  elig, rr_mask, rr_sel, idle_gnt;
    logic [N_REQ-1:0]  gnt_c, gnt_o, rvalid_q;
    logic              mac_wr, lock_timeout_hit, any_gnt;
    logic [ADDR_W-1:0] addr_q, addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              err_mac_q, err_to_q;

    // MAC has read-only access to the bank: a MAC write never competes
    assign mac_wr = bus.req[MAC] & bus.req_we[MAC];

    always_comb begin
        elig      = bus.req;
        elig[MAC] = bus.req[MAC] & ~bus.req_we[MAC];
        rr_mask   = elig;
        rr_mask[BUS_FSM] = 1'b0;
    end

    rr_picker #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_picker (
        .mask   (rr_mask),
        .rr_ptr (rr_ptr),
        .sel    (rr_sel)
    );

    assign idle_gnt = elig[BUS_FSM] ? N_REQ'(1) : rr_sel;
    assign win_idx  = onehot_to_idx(idle_gnt);

    always_comb begin
        state_nxt        = state;
        owner_nxt        = owner;
        rr_ptr_nxt       = rr_ptr;
        lock_cnt_nxt     = lock_cnt;
        gnt_c            = '0;
        lock_timeout_hit = 1'b0;

        if (state == IDLE || !bus.req_lock[owner]) begin
            // Per-cycle arbitration; also used on the cycle a lock is dropped
            gnt_c     = idle_gnt;
            state_nxt = IDLE;
            if (|idle_gnt) begin
                if (win_idx != PTR_W'(BUS_FSM)) begin
                    rr_ptr_nxt = ptr_after(win_idx);
                end
                if (bus.req_lock[win_idx]) begin
                    state_nxt    = LOCKED;
                    owner_nxt    = win_idx;
                    lock_cnt_nxt = '0;
                end
            end
        end else begin
            gnt_c[owner] = elig[owner];
            lock_cnt_nxt = lock_cnt + CNT_W'(1);
            if (lock_cnt == CNT_LAST) begin
                state_nxt        = IDLE;
                lock_timeout_hit = 1'b1;
                rr_ptr_nxt       = ptr_after(owner);
                lock_cnt_nxt     = '0;
            end
        end
    end

    assign gnt_o     = rst ? '0 : gnt_c;
    assign gnt_idx   = onehot_to_idx(gnt_o);
    assign any_gnt   = |gnt_o;
    assign addr_sel  = bus.req_addr[gnt_idx];
    assign wdata_sel = bus.req_wdata[gnt_idx];

    assign bus.gnt       = gnt_o;
    assign bus.mem_en    = any_gnt;
    assign bus.mem_wen   = |(gnt_o & bus.req_we);
    assign bus.mem_addr  = any_gnt ? addr_sel : addr_q;
    assign bus.mem_wdata = any_gnt ? wdata_sel : '0;
    assign bus.rvalid    = rvalid_q;
    // The macro already delivers read data one cycle after the grant
    assign bus.rdata     = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= PTR_W'(1);
            lock_cnt  <= '0;
            rvalid_q  <= '0;
            addr_q    <= '0;
            err_mac_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            lock_cnt <= lock_cnt_nxt;
            rvalid_q <= gnt_o & ~bus.req_we;
            if (any_gnt) begin
                addr_q <= addr_sel;
            end
            if (mac_wr) begin
                err_mac_q <= 1'b1;
            end
            if (lock_timeout_hit) begin
                err_to_q <= 1'b1;
            end
        end
    end

    assign busy             = (state == LOCKED);
    assign err_mac_write    = err_mac_q;
    assign err_lock_timeout = err_to_q;
    assign dbg_state        = state;

endmodule

// File: tb/tb_cim_mem_arbiter.sv
// Directed bench for cim_mem_arbiter: grant order, locking, timeout, errors,
// reset behaviour; read returns checked through an expected-data queue.
module tb_cim_mem_arbiter;
    import cim_mem_arbiter_pkg::*;

    localparam int N_REQ  = 6;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       err_mac_write;
    logic       err_lock_timeout;
    arb_state_e dbg_state;

    int n_cmp;
    int n_err;
    logic [N_REQ+DATA_W-1:0] exp_q[$];
    logic [N_REQ+DATA_W-1:0] mon_got;
    logic [DATA_W-1:0]       tb_mem [int];

    cim_mem_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cim_mem_arbiter #(
        .N_REQ        (N_REQ),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LOCK_TIMEOUT (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .busy             (busy),
        .err_mac_write    (err_mac_write),
        .err_lock_timeout (err_lock_timeout),
        .dbg_state        (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- memory model ----------------
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (a == 11'h010) return 16'hABCD;
        return {a[7:0], a[10:3]} ^ 16'h3C5A;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wen) begin
                tb_mem[int'(bus.mem_addr)] = bus.mem_wdata;
            end else if (tb_mem.exists(int'(bus.mem_addr))) begin
                bus.mem_rdata <= tb_mem[int'(bus.mem_addr)];
            end else begin
                bus.mem_rdata <= exp_data(bus.mem_addr);
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (|bus.rvalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL rvalid_unexpected observed=%0h expected=none", bus.rvalid);
            end else begin
                mon_got = exp_q.pop_front();
                assert ({bus.rvalid, bus.rdata} === mon_got) else begin
                    n_err++;
                    $error("FAIL rdata_return observed=%0h expected=%0h", {bus.rvalid, bus.rdata}, mon_got);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic r, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic [2:0] ki;
        ki = 3'(k);
        bus.req[ki]       = r;
        bus.req_we[ki]    = we;
        bus.req_lock[ki]  = lk;
        bus.req_addr[ki]  = a;
        bus.req_wdata[ki] = d;
    endtask

    task automatic clear_all();
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_lock = '0;
    endtask

    // Settle, compare gnt with the expected winner (-1 = none), queue read data
    task automatic cyc(input string tag, input int k);
        logic [N_REQ-1:0] e;
        logic [2:0]       ki;
        #1;
        e  = (k >= 0) ? (N_REQ'(1) << k) : '0;
        ki = 3'((k >= 0) ? k : 0);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(e));
        if (k >= 0 && !bus.req_we[ki]) begin
            exp_q.push_back({e, exp_data(bus.req_addr[ki])});
        end
    endtask

    task automatic step(input string tag, input int k);
        cyc(tag, k);
        tick();
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        clear_all();
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        tick();
        tick();

        // reset state, with every requester asking
        bus.req = '1;
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_mac", 32'(err_mac_write), 0);
        chk("rst_err_to", 32'(err_lock_timeout), 0);
        chk("rst_rvalid", 32'(bus.rvalid), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        clear_all();
        rst = 1'b0;
        tick();

        // single read from LAYERNORM
        drive(3, 1, 0, 0, 11'h010, 0);
        cyc("rd_single", 3);
        chk("rd_single_addr", 32'(bus.mem_addr), 32'h010);
        chk("rd_single_wen", 32'(bus.mem_wen), 0);
        tick();
        clear_all();
        chk("rd_single_rvalid", 32'(bus.rvalid), 32'h08);
        chk("rd_single_rdata", 32'(bus.rdata), 32'hABCD);
        step("rd_idle", -1);
        chk("rd_rvalid_clr", 32'(bus.rvalid), 0);

        // contention: BUS_FSM holds the bank, then LOGIC/DATA_FILL alternate
        do_reset();
        drive(0, 1, 0, 0, 11'h100, 0);
        drive(1, 1, 0, 0, 11'h108, 0);
        drive(4, 1, 0, 0, 11'h120, 0);
        for (int i = 0; i < 3; i++) step("cont_bus", 0);
        drive(0, 0, 0, 0, 11'h100, 0);
        step("cont_a", 1);
        step("cont_b", 4);
        step("cont_c", 1);
        step("cont_d", 4);
        clear_all();
        step("cont_idle", -1);
        step("cont_idle", -1);

        // round-robin over 1,3,4,5
        do_reset();
        drive(1, 1, 0, 0, 11'h201, 0);
        drive(3, 1, 0, 0, 11'h203, 0);
        drive(4, 1, 0, 0, 11'h204, 0);
        drive(5, 1, 0, 0, 11'h205, 0);
        step("rr_1", 1);
        step("rr_3", 3);
        step("rr_4", 4);
        step("rr_5", 5);
        step("rr_wrap", 1);
        clear_all();
        step("rr_idle", -1);
        step("rr_idle", -1);

        // lock by DATA_FILL_FSM while BUS_FSM waits
        do_reset();
        drive(4, 1, 0, 1, 11'h300, 0);
        cyc("lock_enter", 4);
        chk("lock_busy_pre", 32'(busy), 0);
        tick();
        drive(0, 1, 0, 0, 11'h308, 0);
        for (int i = 0; i < 4; i++) begin
            cyc("lock_hold", 4);
            chk("lock_busy", 32'(busy), 1);
            tick();
        end
        drive(4, 1, 0, 0, 11'h300, 0);
        cyc("lock_release", 0);
        chk("lock_busy_rel", 32'(busy), 1);
        tick();
        cyc("lock_after", 0);
        chk("lock_busy_after", 32'(busy), 0);
        tick();
        clear_all();
        step("lock_idle", -1);
        step("lock_idle", -1);

        // lock timeout
        do_reset();
        drive(4, 1, 0, 1, 11'h400, 0);
        step("to_enter", 4);
        drive(1, 1, 0, 0, 11'h410, 0);
        for (int i = 0; i < 64; i++) begin
            cyc("to_hold", 4);
            if (i == 63) begin
                chk("to_err_pre", 32'(err_lock_timeout), 0);
                chk("to_busy_pre", 32'(busy), 1);
            end
            tick();
        end
        cyc("to_next", 1);
        chk("to_err", 32'(err_lock_timeout), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_state", 32'(dbg_state), 32'(IDLE));
        tick();
        step("to_relock", 4);
        clear_all();
        step("to_idle", -1);
        step("to_idle", -1);
        chk("to_err_sticky", 32'(err_lock_timeout), 1);

        // MAC write attempt plus LOGIC_FSM read
        do_reset();
        drive(2, 1, 1, 0, 11'h500, 16'hDEAD);
        drive(1, 1, 0, 0, 11'h510, 0);
        cyc("mac_wr", 1);
        chk("mac_wr_wen", 32'(bus.mem_wen), 0);
        chk("mac_err_pre", 32'(err_mac_write), 0);
        tick();
        chk("mac_err", 32'(err_mac_write), 1);
        clear_all();
        drive(2, 1, 1, 0, 11'h500, 16'hDEAD);
        cyc("mac_alone", -1);
        chk("mac_alone_en", 32'(bus.mem_en), 0);
        tick();
        clear_all();
        step("mac_idle", -1);
        chk("mac_err_sticky", 32'(err_mac_write), 1);
        chk("mac_to_clr", 32'(err_lock_timeout), 0);

        // granted write, then address hold with no grant
        drive(3, 1, 1, 0, 11'h020, 16'h1111);
        cyc("wr", 3);
        chk("wr_wen", 32'(bus.mem_wen), 1);
        chk("wr_addr", 32'(bus.mem_addr), 32'h020);
        chk("wr_wdata", 32'(bus.mem_wdata), 32'h1111);
        tick();
        clear_all();
        cyc("wr_idle", -1);
        chk("wr_addr_hold", 32'(bus.mem_addr), 32'h020);
        chk("wr_idle_wen", 32'(bus.mem_wen), 0);
        chk("wr_no_rvalid", 32'(bus.rvalid), 0);
        tick();

        // reset in the middle of a lock
        drive(5, 1, 0, 1, 11'h600, 0);
        step("rl_enter", 5);
        cyc("rl_hold", 5);
        chk("rl_busy", 32'(busy), 1);
        tick();
        rst = 1'b1;
        cyc("rl_rst", -1);
        chk("rl_rvalid_pend", 32'(bus.rvalid), 32'h20);
        tick();
        chk("rl_busy_clr", 32'(busy), 0);
        chk("rl_rvalid_clr", 32'(bus.rvalid), 0);
        rst = 1'b0;
        clear_all();
        step("rl_idle", -1);
        step("rl_idle", -1);

        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cim_mem_arbiter.md
# cim_mem_arbiter

Arbiter and sequencer for one single-port CIM memory bank (intermediate results or parameters). It takes per-requester request/write/lock signals from the six CIM engines: BUS_FSM, LOGIC_FSM, MAC, LAYERNORM, DATA_FILL_FSM and DENSE_BROADCAST_SAVE_FSM. It drives exactly one access per cycle into the memory and routes tagged read-valid back to the winner. BUS_FSM has fixed top priority, the remaining engines share the bank round-robin, and a lock lets an engine own the bank for an atomic multi-cycle sequence.

## Interface
Parameters:
- N_REQ, 6, number of requesters; index = one-hot position from the shared requester enum.
- ADDR_W, 11, memory address width.
- DATA_W, N_STORAGE, word width.
- LOCK_TIMEOUT, 64, maximum consecutive cycles in LOCKED.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  synchronous, active-high reset.
- Requester side:
  - req  in  N_REQ  access request.
  - req_we  in  N_REQ  1 = write, 0 = read.
  - req_lock  in  N_REQ  request exclusive ownership.
  - req_addr  in  N_REQ x ADDR_W  per-requester address.
  - req_wdata  in  N_REQ x DATA_W  per-requester write data.
  - gnt  out  N_REQ  one-hot grant, combinational.
  - rvalid  out  N_REQ  one-hot read-data-valid, registered.
  - rdata  out  DATA_W  read data, shared; qualified by rvalid.
- Memory side:
  - mem_en  out  1  access this cycle.
  - mem_wen  out  1  write enable.
  - mem_addr  out  ADDR_W  address.
  - mem_wdata  out  DATA_W  write data.
  - mem_rdata  in  DATA_W  read data, 1-cycle latency.
- Status:
  - busy  out  1  high when in LOCKED state.
  - err_mac_write  out  1  sticky: MAC requested a write.
  - err_lock_timeout  out  1  sticky: lock exceeded LOCK_TIMEOUT.

## Operation
- **States:**
  - IDLE: per-cycle arbitration.
  - LOCKED: single owner.
- **IDLE arbitration:**
  - req[BUS_FSM] wins unconditionally.
  - Otherwise, round-robin over indices 1..N_REQ-1, starting at rr_ptr.
  - After a grant to k ≥ 1, rr_ptr = k+1, wrapping N_REQ-1 → 1.
  - A BUS_FSM grant leaves rr_ptr unchanged.
- **MAC write:** req[MAC] && req_we[MAC] is never granted. It is excluded from arbitration that cycle and sets err_mac_write.
- **Entering LOCKED:** if the granted k has req_lock[k]=1, the next state is LOCKED, owner=k and lock_cnt=0.
- **In LOCKED:**
  - Only the owner can be granted (gnt[owner]=req[owner]); BUS_FSM is blocked too.
  - lock_cnt increments every cycle.
- **Leaving LOCKED:**
  - When req_lock[owner]=0, that same cycle is arbitrated with IDLE rules, and the state returns to IDLE.
  - When lock_cnt reaches LOCK_TIMEOUT-1, the state is forced to IDLE, err_lock_timeout is set, and rr_ptr moves past the owner.
- **Memory drive:**
  - mem_en = |gnt.
  - mem_wen = |(gnt & req_we).
  - mem_addr and mem_wdata take the winner's values.
  - With no grant, mem_addr holds its last granted value (register, not latch) and mem_wen=0.
- **Errors:** sticky until rst.

## Timing
- gnt and mem_* are valid in the same cycle as req; the memory samples at the next clk edge.
- A read granted in cycle t gives rvalid[k]=1 and rdata=mem_rdata in cycle t+1.
- A write is committed at the end of cycle t; no rvalid is produced for it.
- Back-to-back grants to different requesters are allowed every cycle with no bubble.
- Requesters must hold req, addr and data until they see gnt. Unchanged inputs give a stable grant within a cycle.
- **Reset values:**
  - state IDLE, rr_ptr=1, lock_cnt=0.
  - rvalid=0, mem_addr=0.
  - err_* = 0, busy=0.
  - gnt, mem_en and mem_wen are forced to 0 while rst=1.
- **Reset mid-operation:** the lock is released and any pending rvalid is dropped (0 the cycle after rst).
- **Simultaneous events:**
  - An owner deasserting lock while BUS_FSM requests: BUS_FSM wins that cycle.
  - A MAC write plus other requests: the others are arbitrated normally.
- busy is high during LOCKED, registered from the state.

## Structure
- Shared CIM package holds:
  - the requester index enum (BUS_FSM=0, LOGIC_FSM=1, MAC=2, LAYERNORM=3, DATA_FILL_FSM=4, DENSE_BROADCAST_SAVE_FSM=5) and N_REQ;
  - the ArbState enum (IDLE, LOCKED);
  - N_STORAGE and the storage-size constants.
- One sub-module, rr_picker: a combinational round-robin select with inputs (mask, rr_ptr) and a one-hot output. It is reused by other CIM schedulers.
- Instantiated twice per CIM: once for the int_res bank and once for the params bank.

## Test plan
- Single read: req[LAYERNORM], addr 0x10 preloaded with 0xABCD → gnt[3] same cycle, rvalid[3]=1 and rdata=0xABCD next cycle.
- Contention: BUS_FSM, LOGIC_FSM and DATA_FILL_FSM request continuously → grant order 0,0,0… while BUS_FSM is held; then drop BUS_FSM → 1,4,1,4 alternating.
- Round-robin: req on 1,3,4,5 held from reset → gnt sequence 1,3,4,5,1.
- Lock: DATA_FILL_FSM locks for 5 cycles with BUS_FSM also requesting → gnt[4] for 5 cycles, busy=1; BUS_FSM is granted in the cycle lock drops.
- Timeout: lock held 70 cycles with LOCK_TIMEOUT=64 → err_lock_timeout set at cycle 64, state IDLE, next grant goes to a different requester.
- MAC write attempt plus LOGIC_FSM read → gnt[1] only, err_mac_write=1 and sticky; rst mid-lock → busy=0 and rvalid=0 the following cycle.
